// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizes for the multi-read-port register file.
package regfile_mp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int DEPTH_DEF  = 8;
  localparam int NUM_RD_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks ptr over 0..DEPTH-1 issuing one zero-write per cycle.
// State is exported on `state` so checkers can observe the sequencer directly.
module regfile_clear_fsm
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output clr_state_t        state
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        state_d;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  // ptr stops at DEPTH-1 and is re-armed to 0, so it never indexes past the array.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    clr_we  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (ptr == LAST) begin
          state_d = DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign clr_addr = ptr;
  assign clr_busy = (state != IDLE);
  assign clr_done = (state == DONE);
  assign wr_ready = (state == IDLE);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NUM_RD combinational read ports and a bulk-clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  // Write handshake: a write transfers on a rising edge where wr_en && wr_ready;
  // wr_en may be held while wr_ready is low, but nothing is queued meanwhile.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  clr_state_t        clr_state;
  logic              wr_ok;
  logic              wr_fire;

  regfile_clear_fsm #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .wr_ready(wr_ready),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .state   (clr_state)
  );

  assign wr_ok   = ({1'b0, wr_addr} < DEPTH_LIM);
  assign wr_fire = wr_en && wr_ready && wr_ok;

  // Clear writes and user writes never coincide: clr_we only occurs while wr_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_ok;
    logic [DATA_W-1:0] stored;

    assign ra     = rd_addr[g*ADDR_W +: ADDR_W];
    assign ra_ok  = ({1'b0, ra} < DEPTH_LIM);
    assign stored = ra_ok ? mem[ra] : '0;
`ifdef REGFILE_MP_BYPASS_EN
    // rst_n gate keeps rd_data at zero while reset is held, even with wr_en high.
    assign rd_data[g*DATA_W +: DATA_W] = (rst_n && wr_fire && (wr_addr == ra)) ? wr_data : stored;
`else
    assign rd_data[g*DATA_W +: DATA_W] = stored;
`endif
  end

  clear_we_only_in_clear: assert property (
    @(posedge clk) disable iff (!rst_n) clr_we |-> (clr_state == CLEAR)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default 8x8, 2 read ports) plus a DEPTH=6 instance.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  logic        w6_en;
  logic [2:0]  w6_addr;
  logic [7:0]  w6_data;
  logic        w6_ready;
  logic [5:0]  r6_addr;
  logic [15:0] r6_data;
  logic        busy6;
  logic        done6;
  logic        clr6;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_mp #(.DATA_W(8), .ADDR_W(3), .DEPTH(6), .NUM_RD(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .wr_en(w6_en), .wr_addr(w6_addr), .wr_data(w6_data),
    .wr_ready(w6_ready), .rd_addr(r6_addr), .rd_data(r6_data), .clr_req(clr6),
    .clr_busy(busy6), .clr_done(done6)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra0;
    logic [2:0] ra1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vecs[7];

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic read_all_expect(input string name, input logic [7:0] v);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) exp_q.push_back(v);
    for (int i = 0; i < 8; i++) begin
      rd_addr = {3'(i), 3'(i)};
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s_p0_a%0d", name, i), rd_data[7:0], e);
      check($sformatf("%s_p1_a%0d", name, i), rd_data[15:8], e);
    end
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    bit seen;
    logic [7:0] exp_fwd;

    vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd0, 3'd1, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 3'd7, 8'h3C, 3'd3, 3'd0, 8'hA5, 8'h00};
    vecs[2] = '{1'b0, 3'd3, 8'hFF, 3'd3, 3'd7, 8'hA5, 8'h3C};
    vecs[3] = '{1'b0, 3'd3, 8'hFF, 3'd3, 3'd7, 8'hA5, 8'h3C};
    vecs[4] = '{1'b1, 3'd1, 8'h12, 3'd7, 3'd3, 8'h3C, 8'hA5};
    vecs[5] = '{1'b1, 3'd6, 8'hC3, 3'd1, 3'd5, 8'h12, 8'h00};
    vecs[6] = '{1'b0, 3'd0, 8'h00, 3'd6, 3'd1, 8'hC3, 8'h12};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; clr_req = 1'b0;
    w6_en = 1'b0; w6_addr = '0; w6_data = '0; r6_addr = '0; clr6 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    #1;
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_clr_busy", clr_busy, 1'b0);
    check("rst_clr_done", clr_done, 1'b0);
    read_all_expect("rst_read", 8'h00);
    step();

    // table-driven write/read vectors
    for (int i = 0; i < 7; i++) begin
      wr_en   = vecs[i].we;
      wr_addr = vecs[i].wa;
      wr_data = vecs[i].wd;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #2;
      check($sformatf("vec%0d_p0", i), rd_data[7:0], vecs[i].e0);
      check($sformatf("vec%0d_p1", i), rd_data[15:8], vecs[i].e1);
      step();
    end
    wr_en = 1'b0;

    // forwarding
`ifdef REGFILE_MP_BYPASS_EN
    exp_fwd = 8'h5A;
`else
    exp_fwd = 8'h00;
`endif
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A; rd_addr = {3'd0, 3'd2};
    #1 check("fwd_same_cycle", rd_data[7:0], exp_fwd);
    step();
    wr_en = 1'b0;
    #1 check("fwd_next_cycle", rd_data[7:0], 8'h5A);
    wr_addr = 3'd2; wr_data = 8'h99;
    #1 check("nofwd_wr_en0", rd_data[7:0], 8'h5A);
    step();
    check("nofwd_wr_en0_next", rd_data[7:0], 8'h5A);

    // DEPTH=6 boundaries
    w6_en = 1'b1; w6_addr = 3'd7; w6_data = 8'h42; r6_addr = {3'd7, 3'd7};
    #1 check("d6_fwd_out_of_range", r6_data[7:0], 8'h00);
    step();
    w6_addr = 3'd5; w6_data = 8'h24;
    step();
    w6_en = 1'b0; r6_addr = {3'd5, 3'd6};
    #1;
    check("d6_read_addr6", r6_data[7:0], 8'h00);
    check("d6_read_addr5", r6_data[15:8], 8'h24);
    r6_addr = {3'd0, 3'd7};
    #1;
    check("d6_read_addr7", r6_data[7:0], 8'h00);
    check("d6_read_addr0", r6_data[15:8], 8'h00);
    check("d6_wr_ready", w6_ready, 1'b1);

    // bulk clear over a full array
    for (int i = 0; i < 8; i++) do_write(3'(i), 8'hFF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h11; rd_addr = {3'd0, 3'd4};
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 1) begin
        check("clr_c1_wr_ready", wr_ready, 1'b0);
        check("clr_c1_no_fwd", rd_data[7:0], 8'hFF);
        check("clr_c1_entry0_old", rd_data[15:8], 8'hFF);
      end
      if (c == 2) begin
        wr_en = 1'b0;
        clr_req = 1'b1;
      end
      if (c == 3) clr_req = 1'b0;
      if (c == 7) check("clr_c7_entry4_zero", rd_data[7:0], 8'h00);
      step();
    end
    check("clr_busy_cycles", 8'(busy_cnt), 8'd9);
    check("clr_done_count", 8'(done_cnt), 8'd1);
    check("clr_done_cycle", 8'(done_cyc), 8'd9);
    check("clr_after_ready", wr_ready, 1'b1);
    read_all_expect("clr_read", 8'h00);

    // write and clr_req on the same edge
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h77; clr_req = 1'b1;
    step();
    wr_en = 1'b0; clr_req = 1'b0; rd_addr = {3'd1, 3'd0};
    #1 check("sim_write_committed", rd_data[7:0], 8'h77);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (clr_done) seen = 1'b1;
      else step();
    end
    check("sim_done_seen", seen, 1'b1);
    step();
    check("sim_addr0_zero", rd_data[7:0], 8'h00);
    check("sim_idle", clr_busy, 1'b0);

    // reset asserted mid-clear
    do_write(3'd5, 8'hEE);
    do_write(3'd3, 8'h33);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (3) step();
    check("midrst_busy_before", clr_busy, 1'b1);
    rd_addr = {3'd3, 3'd5};
    rst_n = 1'b0;
    #1;
    check("midrst_busy", clr_busy, 1'b0);
    check("midrst_done", clr_done, 1'b0);
    check("midrst_wr_ready", wr_ready, 1'b1);
    check("midrst_addr5", rd_data[7:0], 8'h00);
    check("midrst_addr3", rd_data[15:8], 8'h00);
    step();
    rst_n = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      step();
    end
    check("midrst_no_busy", 8'(busy_cnt), 8'd0);
    check("midrst_no_done", 8'(done_cnt), 8'd0);
    read_all_expect("midrst_read", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file. It is the next generation of the 8x8 two-read-port register file in the datapath labs, and sits between instruction decode and the ALU operand muxes. Adds the following over the previous block:
- configurable data width, depth and read-port count;
- qualified write-to-read forwarding;
- an asynchronous active-low reset that clears the array;
- a sequenced bulk-clear engine with a request/busy/done handshake, which blocks writes while it runs.

## Interface
Parameters:
- DATA_W, 8, data width in bits
- ADDR_W, 3, address width
- DEPTH, 8, number of entries; must satisfy 2 <= DEPTH <= 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  high when writes are accepted
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W]
- clr_req  in  1  bulk-clear request, sampled in IDLE only
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse when the clear completes

## Operation
- Write acceptance:
  - A write commits when wr_en && wr_ready at a rising edge: mem[wr_addr] <= wr_data.
  - wr_addr >= DEPTH: the write is dropped silently.
- Reads are combinational:
  - rd_data[i] = mem[rd_addr[i]].
  - rd_addr[i] >= DEPTH returns 0.
- Forwarding (see Configuration) applies when an accepted write targets the same in-range address as a read port.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR, ptr <= 0.
  - CLEAR: each edge sets mem[ptr] <= 0 and ptr <= ptr+1. When ptr == DEPTH-1, that entry is cleared and the next state is DONE.
  - DONE: clr_done=1 for this cycle only, then -> IDLE.
- clr_busy = (state != IDLE).
- wr_ready = (state == IDLE).
- clr_req while CLEAR or DONE: ignored, not queued.
- Write and clr_req at the same IDLE edge: the write commits, CLEAR starts next cycle, and the entry is later zeroed.
- Reads during CLEAR return current contents. An entry being cleared at the current edge still reads its old value in that cycle.

## Timing
- Reset (rst_n low, asynchronous), also when asserted mid-clear, with immediate effect:
  - all mem entries = 0;
  - state = IDLE, ptr = 0;
  - clr_busy = 0, clr_done = 0, wr_ready = 1;
  - rd_data = 0.
- Write latency: data written at edge n is visible on an unforwarded read from cycle n+1.
- Read latency: 0 cycles (combinational from rd_addr and mem).
- Clear latency, with clr_req sampled at edge 0:
  - clr_busy rises after edge 0;
  - entries 0..DEPTH-1 are zeroed at edges 1..DEPTH;
  - clr_done is high in the cycle after edge DEPTH;
  - IDLE is reached after edge DEPTH+1.
  - clr_busy is high for exactly DEPTH+1 cycles.
- ptr is ADDR_W bits wide and never wraps past DEPTH-1.

## Configuration
- Macro REGFILE_MP_BYPASS_EN.
- Defined: for each port i, rd_data[i] = wr_data if wr_en && wr_ready && wr_addr == rd_addr[i] && wr_addr < DEPTH; otherwise the stored value. Forwarding is suppressed whenever wr_ready=0.
- Undefined: no forwarding. Reads always return mem contents; a same-cycle write appears from the next cycle.

## Structure
- Package regfile_mp_pkg holds:
  - the clear-FSM state enum (IDLE, CLEAR, DONE);
  - localparam defaults for DATA_W, ADDR_W, DEPTH, NUM_RD.
- Sub-module regfile_clear_fsm contains the state register and ptr counter. It produces clr_busy, clr_done, wr_ready, clr_we and clr_addr. The array, write decode and read muxes stay in regfile_mp.

## Test plan
- Reset then read: rst_n low for 2 cycles, release, read all 8 entries -> all 0; wr_ready=1, clr_busy=0.
- Write/read: write 0xA5 to addr 3, then 0x3C to addr 7; next cycle read ports 0/1 at 3/7 -> 0xA5/0x3C. Write with wr_en=0 -> no change.
- Forwarding:
  - with the macro: write 0x5A to addr 2 while rd_addr0=2 -> rd_data0=0x5A in the same cycle;
  - without the macro: old value that cycle, 0x5A the next cycle;
  - wr_en=0 with matching address -> no forwarding in either build.
- Bulk clear: fill all entries with 0xFF; pulse clr_req -> clr_busy high for 9 cycles, clr_done high in cycle 9, all entries 0 afterwards. A write of 0x11 during CLEAR is dropped (wr_ready=0). A second clr_req during busy is ignored.
- Simultaneous events and boundaries:
  - write 0x77 to addr 0 on the same edge as clr_req -> addr 0 reads 0 after done;
  - DEPTH=6 build: write to addr 7 is dropped, and a read of addr 6 returns 0.
- Reset mid-clear: assert rst_n low at CLEAR cycle 4 -> immediately IDLE, clr_busy=0, no clr_done pulse, all entries 0, wr_ready=1.
